// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - UART byte-command loader bridging rx/tx bytes to banked byte memories
//
// Decodes a header/address/length/data byte stream from a UART receiver and
// performs burst writes into, or burst read-back out of, one of NUM_BANKS
// byte-addressed memories. Also halts/runs the CPU (cpu_rst).
// Optional feature macro: UART_MEM_LOADER_ACK_EN (acknowledge/checksum bytes).
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_rx_ready/i_rx_data  received byte strobe and value
//   i_tx_empty          transmitter can accept a byte
//   i_tx_error          transmitter saw a request while busy
//   o_tx_req/o_tx_data  1-cycle transmit request and byte
//   o_cpu_rst           CPU held in reset
//   o_mem_ctrl          one-hot bank ownership
//   o_mem_wr_en/o_mem_rd_en/o_mem_addr/o_mem_wr_data  byte memory port
//   i_mem_rd_data       per-bank read bytes, bank b at [8b+7:8b]
//   o_busy              command in progress
//   o_err               sticky error
module uart_mem_loader #(
  parameter int NUM_BANKS           = 2,
  parameter int MEM_BYTE_ADDR_WIDTH = 6,
  parameter int TIMEOUT_CYCLES      = 1 << 20
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_rx_ready,
  input  logic [7:0]                     i_rx_data,
  input  logic                           i_tx_empty,
  input  logic                           i_tx_error,
  output logic                           o_tx_req,
  output logic [7:0]                     o_tx_data,
  output logic                           o_cpu_rst,
  output logic [NUM_BANKS-1:0]           o_mem_ctrl,
  output logic                           o_mem_wr_en,
  output logic                           o_mem_rd_en,
  output logic [MEM_BYTE_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]                     o_mem_wr_data,
  input  logic [8*NUM_BANKS-1:0]         i_mem_rd_data,
  output logic                           o_busy,
  output logic                           o_err
);

  localparam int AW         = MEM_BYTE_ADDR_WIDTH;
  localparam int ADDR_BYTES = (AW + 7) / 8;
  localparam int TW         = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [1:0]    LAST_AB = 2'(ADDR_BYTES - 1);
  localparam logic [TW-1:0] TMO     = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_DEC, S_ADDR, S_LEN, S_WDATA, S_RD_REQ, S_RD_WAIT, S_TX_WAIT
`ifdef UART_MEM_LOADER_ACK_EN
    , S_ACK
`endif
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [3:0]       r_bank;
  logic [1:0]       r_abyte;
  logic [AW-1:0]    r_addr;
  logic [7:0]       r_count;
  logic [TW-1:0]    r_timer;
  logic             r_halted;
  logic             r_tx_req;
  logic [7:0]       r_tx_data;
  logic             r_cpu_rst;
  logic [NUM_BANKS-1:0] r_mem_ctrl;
  logic             r_wr_en;
  logic             r_rd_en;
  logic [AW-1:0]    r_mem_addr;
  logic [7:0]       r_wr_data;
  logic             r_err;
`ifdef UART_MEM_LOADER_ACK_EN
  logic [7:0]       r_sum;
  logic [7:0]       r_ack_byte;
`endif

  logic [NUM_BANKS-1:0] w_onehot;
  logic [7:0]           w_rd_byte;
  logic                 w_bad_bank;
  logic                 w_wait_state;
  logic                 w_stream_state;
  logic                 w_timeout;

  always_comb begin
    w_onehot  = '0;
    w_rd_byte = 8'h00;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_onehot[b] = (r_bank == 4'(b));
      if (r_bank == 4'(b)) w_rd_byte = i_mem_rd_data[8*b +: 8];
    end
  end

  assign w_bad_bank   = ({1'b0, r_bank} >= 5'(NUM_BANKS));
  assign w_wait_state = (r_state == S_ADDR) || (r_state == S_LEN) || (r_state == S_WDATA);
`ifdef UART_MEM_LOADER_ACK_EN
  assign w_stream_state = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT) ||
                          (r_state == S_TX_WAIT) || (r_state == S_ACK);
`else
  assign w_stream_state = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT) ||
                          (r_state == S_TX_WAIT);
`endif
  // Abort only once the gap has exceeded TIMEOUT_CYCLES idle clocks.
  assign w_timeout = w_wait_state && !i_rx_ready && (r_timer == TMO);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= 2'b00;
      r_bank     <= 4'h0;
      r_abyte    <= 2'b00;
      r_addr     <= '0;
      r_count    <= 8'h00;
      r_timer    <= '0;
      r_halted   <= 1'b1;
      r_tx_req   <= 1'b0;
      r_tx_data  <= 8'h00;
      r_cpu_rst  <= 1'b1;
      r_mem_ctrl <= '0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_mem_addr <= '0;
      r_wr_data  <= 8'h00;
      r_err      <= 1'b0;
`ifdef UART_MEM_LOADER_ACK_EN
      r_sum      <= 8'h00;
      r_ack_byte <= 8'h00;
`endif
    end else begin
      r_tx_req <= 1'b0;
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      if (i_tx_error) r_err <= 1'b1;
      if (i_rx_ready && w_stream_state) r_err <= 1'b1;
      if (!w_wait_state || i_rx_ready) r_timer <= '0;
      else                             r_timer <= r_timer + 1'b1;

      case (r_state)
        S_IDLE: begin
          // Ownership is released one cycle after the last write strobe.
          r_mem_ctrl <= '0;
          r_cpu_rst  <= r_halted;
          if (i_rx_ready) begin
            r_op    <= i_rx_data[7:6];
            r_bank  <= i_rx_data[3:0];
            r_state <= S_HDR_DEC;
            if (!i_rx_data[7]) r_cpu_rst <= 1'b1;
`ifdef UART_MEM_LOADER_ACK_EN
            r_sum <= 8'h00;
`endif
          end
        end
        S_HDR_DEC: begin
          r_abyte <= 2'b00;
          if (r_op == OP_RUN || r_op == OP_HALT) begin
            r_halted  <= (r_op == OP_HALT);
            r_cpu_rst <= (r_op == OP_HALT);
`ifdef UART_MEM_LOADER_ACK_EN
            r_ack_byte <= 8'h06;
            r_state    <= S_ACK;
`else
            r_state <= S_IDLE;
`endif
          end else if (w_bad_bank) begin
            r_err <= 1'b1;
`ifdef UART_MEM_LOADER_ACK_EN
            r_ack_byte <= 8'h15;
            r_state    <= S_ACK;
`else
            r_state <= S_IDLE;
`endif
          end else begin
            r_state <= S_ADDR;
          end
        end
        S_ADDR, S_LEN, S_WDATA: begin
          if (w_timeout) begin
            r_err <= 1'b1;
`ifdef UART_MEM_LOADER_ACK_EN
            r_ack_byte <= 8'h15;
            r_state    <= S_ACK;
`else
            r_state <= S_IDLE;
`endif
          end else if (i_rx_ready) begin
            if (r_state == S_ADDR) begin
              // Address arrives LSB first; each byte fills its own 8-bit slice.
              for (int i = 0; i < AW; i++)
                if ((i / 8) == int'(r_abyte)) r_addr[i] <= i_rx_data[i % 8];
              r_abyte <= r_abyte + 2'b01;
              if (r_abyte == LAST_AB) r_state <= S_LEN;
            end else if (r_state == S_LEN) begin
              r_count    <= i_rx_data;
              r_mem_ctrl <= w_onehot;
              r_state    <= (r_op == OP_WRITE) ? S_WDATA : S_RD_REQ;
            end else begin
              r_wr_en    <= 1'b1;
              r_mem_addr <= r_addr;
              r_wr_data  <= i_rx_data;
              r_addr     <= r_addr + 1'b1;
              r_count    <= r_count - 8'h01;
`ifdef UART_MEM_LOADER_ACK_EN
              r_sum <= r_sum + i_rx_data;
              if (r_count == 8'h00) begin
                r_ack_byte <= r_sum + i_rx_data;
                r_state    <= S_ACK;
              end
`else
              if (r_count == 8'h00) r_state <= S_IDLE;
`endif
            end
          end
        end
        S_RD_REQ: begin
          r_rd_en    <= 1'b1;
          r_mem_addr <= r_addr;
          r_addr     <= r_addr + 1'b1;
          r_state    <= S_RD_WAIT;
        end
        S_RD_WAIT: r_state <= S_TX_WAIT;
        S_TX_WAIT: begin
          // !r_tx_req keeps back-to-back requests at least two cycles apart.
          if (i_tx_empty && !r_tx_req) begin
            r_tx_req  <= 1'b1;
            r_tx_data <= w_rd_byte;
            r_count   <= r_count - 8'h01;
            r_state   <= (r_count == 8'h00) ? S_IDLE : S_RD_REQ;
          end
        end
`ifdef UART_MEM_LOADER_ACK_EN
        S_ACK: begin
          if (i_tx_empty && !r_tx_req) begin
            r_tx_req  <= 1'b1;
            r_tx_data <= r_ack_byte;
            r_state   <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_req      = r_tx_req;
  assign o_tx_data     = r_tx_data;
  assign o_cpu_rst     = r_cpu_rst;
  assign o_mem_ctrl    = r_mem_ctrl;
  assign o_mem_wr_en   = r_wr_en;
  assign o_mem_rd_en   = r_rd_en;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wr_data = r_wr_data;
  assign o_busy        = (r_state != S_IDLE);
  assign o_err         = r_err;

endmodule
